// File: rtl/ahb_pkg.sv
// Shared AHB types for the wait-state slave: transfer/burst/size encodings,
// response codes and the data-phase state encoding.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_t;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_slv_mem.sv
// Byte-lane memory for the AHB slave: per-byte write enables, combinational read.
// Contents are intentionally not reset.
module ahb_slv_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 512
) (
    input  logic                      h_clk,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [$clog2(WORDS)-1:0]  word_addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);
    localparam int NB = DATA_WIDTH / 8;

    logic [NB-1:0][7:0] mem [0:WORDS-1];

    always_ff @(posedge h_clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[word_addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[word_addr];

endmodule

// File: rtl/ahb_slave_ws.sv
// AHB-Lite memory slave with a fixed number of wait states and two-cycle ERROR responses.
// Optional build macro AHB_SLV_WSTRB_EN additionally gates written bytes with h_wstrb.
module ahb_slave_ws
    import ahb_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          MEM_BYTES   = 2048,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          WAIT_STATES = 2
) (
    input  logic                    h_clk,
    input  logic                    h_resetn,
    input  logic                    h_sel,
    input  logic [ADDR_WIDTH-1:0]   h_addr,
    input  logic [1:0]              h_trans,
    input  logic [2:0]              h_size,
    input  logic [2:0]              h_burst,
    input  logic                    h_write,
    input  logic [DATA_WIDTH-1:0]   h_wdata,
    input  logic [DATA_WIDTH/8-1:0] h_wstrb,
    input  logic                    h_ready,
    output logic [DATA_WIDTH-1:0]   h_rdata,
    output logic                    h_ready_out,
    output logic                    h_resp
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t              state, state_next;
    logic [3:0]          count, count_next;
    logic [MEM_AW-1:0]   addr_q;
    logic [2:0]          size_q;
    logic                write_q;
    logic [ADDR_WIDTH-1:0] offset, size_mask;
    logic                accept, legal;
    logic [NB-1:0]       lane_en, mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    int                  lane_off;

    // Below-base addresses wrap to huge offsets, so one compare covers both range ends.
    assign offset    = h_addr - BASE;
    assign size_mask = (ADDR_WIDTH'(1) << h_size) - ADDR_WIDTH'(1);
    assign legal     = (offset < ADDR_WIDTH'(MEM_BYTES)) && (h_size <= 3'(LANE_W))
                       && ((h_addr & size_mask) == '0);
    assign accept    = h_sel && h_ready && h_ready_out
                       && (h_trans == HTRANS_NONSEQ || h_trans == HTRANS_SEQ);

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state   <= ST_IDLE;
            count   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                addr_q  <= offset[MEM_AW-1:0];
                size_q  <= h_size;
                write_q <= h_write;
            end
        end
    end

    // IDLE, DONE and ERR2 all end a data phase, so each may start the next transfer.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_next = ST_ERR1;
                        count_next = 4'd0;
                    end else begin
                        state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
                        count_next = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (count == 4'd0) state_next = ST_DONE;
                else               count_next = count - 4'd1;
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    assign h_ready_out = !(state == ST_WAIT || state == ST_ERR1);
    assign h_resp      = (state == ST_ERR1 || state == ST_ERR2) ? RESP_ERROR : RESP_OKAY;

    assign lane_off = int'(addr_q[LANE_W-1:0]);

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < NB; i++) begin
            lane_en[i] = (i >= lane_off) && (i < lane_off + (1 << size_q));
        end
    end

`ifdef AHB_SLV_WSTRB_EN
    assign mem_be = lane_en & h_wstrb;
    logic unused_inputs;
    assign unused_inputs = ^h_burst;
`else
    assign mem_be = lane_en;
    logic unused_inputs;
    assign unused_inputs = ^{h_burst, h_wstrb};
`endif

    always_comb begin
        h_rdata = '0;
        for (int i = 0; i < NB; i++) begin
            if (state == ST_DONE && !write_q && lane_en[i]) h_rdata[8*i +: 8] = mem_rdata[8*i +: 8];
        end
    end

    ahb_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (MEM_BYTES / NB)
    ) u_mem (
        .h_clk     (h_clk),
        .we        (state == ST_DONE && write_q),
        .be        (mem_be),
        .word_addr (addr_q[MEM_AW-1:LANE_W]),
        .wdata     (h_wdata),
        .rdata     (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_slave_ws.sv
// Scoreboard bench for ahb_slave_ws: one instance with two wait states, one with none.
// The driver queues expected responses; a negedge monitor compares every data-phase cycle.
module tb_ahb_slave_ws;
    import ahb_pkg::*;

    typedef struct {
        int          waits;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        h_clk = 1'b0;
    logic        h_resetn;
    logic        h_sel;
    logic [31:0] h_addr;
    logic [1:0]  h_trans;
    logic [2:0]  h_size;
    logic [2:0]  h_burst;
    logic        h_write;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1, resp0, resp1;
    logic        unit;
    logic        act_rdy;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 h_clk = ~h_clk;
    assign act_rdy = unit ? rdy1 : rdy0;

    ahb_slave_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(2048), .BASE_ADDR(0), .WAIT_STATES(2)) dut_ws2 (
        .h_clk(h_clk), .h_resetn(h_resetn), .h_sel(h_sel && !unit), .h_addr(h_addr),
        .h_trans(h_trans), .h_size(h_size), .h_burst(h_burst), .h_write(h_write),
        .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_ready(rdy0),
        .h_rdata(rdata0), .h_ready_out(rdy0), .h_resp(resp0));

    ahb_slave_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(2048), .BASE_ADDR(0), .WAIT_STATES(0)) dut_ws0 (
        .h_clk(h_clk), .h_resetn(h_resetn), .h_sel(h_sel && unit), .h_addr(h_addr),
        .h_trans(h_trans), .h_size(h_size), .h_burst(h_burst), .h_write(h_write),
        .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_ready(rdy1),
        .h_rdata(rdata1), .h_ready_out(rdy1), .h_resp(resp1));

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the edge where the bus was ready.
    task automatic step_until_ready();
        int n = 0;
        while (act_rdy !== 1'b1 && n < 40) begin
            @(posedge h_clk); #1;
            n++;
        end
        if (n >= 40) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL driver_timeout: got ready=%b, expected ready=1", act_rdy);
        end
        @(posedge h_clk); #1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input logic [1:0] trans, input logic [31:0] exp_rdata, input logic err);
        exp_t e;
        e.waits = err ? 1 : (unit ? 0 : 2);
        e.err   = err;
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        h_sel = 1'b1; h_addr = addr; h_size = size; h_write = wr; h_trans = trans;
        step_until_ready();
        h_wdata = wdata;
        h_wstrb = strb;
    endtask

    task automatic idle_bus();
        h_sel = 1'b0; h_trans = HTRANS_IDLE;
        step_until_ready();
    endtask

    // Monitor: every cycle is either idle (zero-wait OKAY) or part of a queued data phase.
    always @(negedge h_clk) begin : monitor
        logic        rdy, rsp, addr_now;
        logic [31:0] rd;
        exp_t        e;
        static bit   in_data = 1'b0;
        static int   waits = 0;
        rdy = unit ? rdy1 : rdy0;
        rsp = unit ? resp1 : resp0;
        rd  = unit ? rdata1 : rdata0;
        addr_now = h_sel && rdy && (h_trans == HTRANS_NONSEQ || h_trans == HTRANS_SEQ);
        if (!h_resetn) begin
            exp_q.delete();
            in_data = 1'b0;
            waits = 0;
            check_output("reset_ready", 32'(rdy), 32'd1);
            check_output("reset_resp", 32'(rsp), 32'd0);
            check_output("reset_rdata", rd, 32'd0);
        end else if (in_data) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_phase", 32'(exp_q.size()), 32'd1);
                in_data = 1'b0;
            end else begin
                e = exp_q[0];
                if (!rdy) begin
                    waits++;
                    check_output("wait_resp", 32'(rsp), 32'(e.err));
                    check_output("wait_rdata", rd, 32'd0);
                    if (waits > 20) begin
                        check_output("wait_timeout", 32'(waits), 32'(e.waits));
                        void'(exp_q.pop_front());
                        in_data = 1'b0;
                        waits = 0;
                    end
                end else begin
                    check_output("wait_count", 32'(waits), 32'(e.waits));
                    check_output("done_resp", 32'(rsp), 32'(e.err));
                    check_output("done_rdata", rd, e.rdata);
                    void'(exp_q.pop_front());
                    waits = 0;
                    in_data = addr_now;
                end
            end
        end else begin
            check_output("idle_ready", 32'(rdy), 32'd1);
            check_output("idle_resp", 32'(rsp), 32'd0);
            check_output("idle_rdata", rd, 32'd0);
            in_data = addr_now;
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] strb_exp;
`ifdef AHB_SLV_WSTRB_EN
        strb_exp = 32'h00220044;
`else
        strb_exp = 32'h11223344;
`endif
        unit = 1'b0; h_resetn = 1'b0; h_sel = 1'b0; h_addr = '0; h_trans = HTRANS_IDLE;
        h_size = HSIZE_WORD; h_burst = HBURST_SINGLE; h_write = 1'b0; h_wdata = '0; h_wstrb = 4'hF;
        repeat (3) @(posedge h_clk);
        #1 h_resetn = 1'b1;

        // Two-wait-state slave: write/read-back, errors, top-of-range word.
        apply_stimulus(1, 32'h10,  HSIZE_WORD,  32'hDEADBEEF, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        apply_stimulus(0, 32'h10,  HSIZE_WORD,  32'h0, 4'hF, HTRANS_NONSEQ, 32'hDEADBEEF, 0);
        apply_stimulus(0, 32'h800, HSIZE_WORD,  32'h0, 4'hF, HTRANS_NONSEQ, 32'h0, 1);
        apply_stimulus(0, 32'h12,  HSIZE_WORD,  32'h0, 4'hF, HTRANS_NONSEQ, 32'h0, 1);
        apply_stimulus(0, 32'h10,  HSIZE_DWORD, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h0, 1);
        apply_stimulus(1, 32'h7FC, HSIZE_WORD,  32'hA5A55A5A, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        apply_stimulus(0, 32'h7FC, HSIZE_WORD,  32'h0, 4'hF, HTRANS_NONSEQ, 32'hA5A55A5A, 0);
        idle_bus();

        // BUSY with select held is a zero-wait OKAY, not a transfer.
        h_sel = 1'b1; h_trans = HTRANS_BUSY; h_addr = 32'h10;
        repeat (2) @(posedge h_clk);
        #1 h_sel = 1'b0; h_trans = HTRANS_IDLE;

        // Sub-word lanes and strobes.
        apply_stimulus(1, 32'h60, HSIZE_WORD, 32'h01020304, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        apply_stimulus(1, 32'h61, HSIZE_BYTE, 32'h0000AB00, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        apply_stimulus(0, 32'h60, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h0102AB04, 0);
        apply_stimulus(0, 32'h62, HSIZE_BYTE, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h00020000, 0);
        apply_stimulus(0, 32'h62, HSIZE_HALF, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h01020000, 0);
        apply_stimulus(0, 32'h61, HSIZE_HALF, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h0, 1);
        apply_stimulus(1, 32'h50, HSIZE_WORD, 32'h00000000, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        apply_stimulus(1, 32'h50, HSIZE_WORD, 32'h11223344, 4'h5, HTRANS_NONSEQ, 32'h0, 0);
        apply_stimulus(0, 32'h50, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, strb_exp, 0);
        apply_stimulus(1, 32'h40, HSIZE_WORD, 32'h13579BDF, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        idle_bus();

        // Reset in the first wait cycle of a write must abort it.
        apply_stimulus(1, 32'h40, HSIZE_WORD, 32'hCAFEF00D, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        h_sel = 1'b0; h_trans = HTRANS_IDLE;
        #1 h_resetn = 1'b0;
        repeat (2) @(posedge h_clk);
        #1 h_resetn = 1'b1;
        apply_stimulus(0, 32'h40, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h13579BDF, 0);
        idle_bus();

        // Zero-wait-state slave: INCR4 writes then reads, and write-then-read of one address.
        unit = 1'b1;
        h_burst = HBURST_INCR4;
        for (int k = 0; k < 4; k++)
            apply_stimulus(1, 32'h20 + 32'(4*k), HSIZE_WORD, 32'hA0B0C000 + 32'(k), 4'hF,
                           (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h0, 0);
        for (int k = 0; k < 4; k++)
            apply_stimulus(0, 32'h20 + 32'(4*k), HSIZE_WORD, 32'h0, 4'hF,
                           (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'hA0B0C000 + 32'(k), 0);
        h_burst = HBURST_SINGLE;
        apply_stimulus(1, 32'h30,  HSIZE_WORD, 32'h5EED1234, 4'hF, HTRANS_NONSEQ, 32'h0, 0);
        apply_stimulus(0, 32'h30,  HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h5EED1234, 0);
        apply_stimulus(0, 32'h800, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, 32'h0, 1);
        idle_bus();
        repeat (3) @(posedge h_clk);

        if (exp_q.size() != 0) check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
